// File: rtl/ss_scan_mux_if.sv
// Bundle for the scanner: digit register-file write port plus the per-slot
// code/enable/digit-select outputs feeding the seven-segment glyph driver.
interface ss_scan_mux_if;
    logic       wr_en;
    logic [1:0] wr_digit;
    logic [0:3] wr_code;
    logic       wr_on;
    logic       wr_blink;

    logic [0:3] code;
    logic       enable;
    logic [0:3] an_n;
    logic       frame_start;

    // Writes are fire-and-forget: a strobe with wr_en=1 is always accepted,
    // so there is no ready/valid pairing on this port.
    modport master (
        output wr_en, wr_digit, wr_code, wr_on, wr_blink,
        input  code, enable, an_n, frame_start
    );

    modport slave (
        input  wr_en, wr_digit, wr_code, wr_on, wr_blink,
        output code, enable, an_n, frame_start
    );
endinterface

// File: rtl/ss_scan_mux.sv
// Four-digit time-multiplexed scanner with per-slot blanking window.
// Optional blinking is compiled in with `define SS_SCAN_BLINK_EN.
module ss_scan_mux #(
    parameter int SLOT_CYCLES  = 1024,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    ss_scan_mux_if.slave  bus
);

    localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic          cnt_wrap;
    logic          in_blank;

    logic [0:3]    ent_code_q [4];
    logic          ent_on_q   [4];

    logic [0:3]    code_q, code_d;
    logic          enable_q, enable_d;
    logic [0:3]    an_n_q, an_n_d;
    logic          frame_start_q, frame_start_d;

    logic          blink_dark;
    logic          cur_blink;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                ent_code_q[i] <= '0;
                ent_on_q[i]   <= 1'b0;
            end
        end else if (bus.wr_en) begin
            ent_code_q[bus.wr_digit] <= bus.wr_code;
            ent_on_q[bus.wr_digit]   <= bus.wr_on;
        end
    end

`ifdef SS_SCAN_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic          ent_blink_q [4];
    logic [FW-1:0] frame_q;
    logic          blink_dark_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                ent_blink_q[i] <= 1'b0;
            end
        end else if (bus.wr_en) begin
            ent_blink_q[bus.wr_digit] <= bus.wr_blink;
        end
    end

    // One frame ends when the last slot of digit 3 wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q      <= '0;
            blink_dark_q <= 1'b0;
        end else if (cnt_wrap && (idx_q == 2'd3)) begin
            if (frame_q == FRAME_LAST) begin
                frame_q      <= '0;
                blink_dark_q <= ~blink_dark_q;
            end else begin
                frame_q <= frame_q + 1'b1;
            end
        end
    end

    assign blink_dark = blink_dark_q;
    assign cur_blink  = ent_blink_q[idx_q];
`else
    logic unused_blink;
    assign unused_blink = &{1'b0, bus.wr_blink};
    assign blink_dark   = 1'b0;
    assign cur_blink    = 1'b0;
`endif

    always_comb begin
        cnt_wrap = (cnt_q == CNT_LAST);
        cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;
        idx_d    = cnt_wrap ? idx_q + 2'd1 : idx_q;
        in_blank = (int'(cnt_q) < BLANK_CYCLES);

        // Outputs for this edge come from the pre-edge counters and entries,
        // so a write lands on the pins one edge after its own write edge.
        code_d        = ent_code_q[idx_q];
        an_n_d        = 4'b1111;
        enable_d      = 1'b0;
        frame_start_d = (cnt_q == '0) && (idx_q == 2'd0);
        if (!in_blank) begin
            an_n_d[idx_q] = 1'b0;
            enable_d      = ent_on_q[idx_q] && !(blink_dark && cur_blink);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= 2'd0;
            code_q        <= 4'b0000;
            enable_q      <= 1'b0;
            an_n_q        <= 4'b1111;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            code_q        <= code_d;
            enable_q      <= enable_d;
            an_n_q        <= an_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.code        = code_q;
    assign bus.enable      = enable_q;
    assign bus.an_n        = an_n_q;
    assign bus.frame_start = frame_start_q;

endmodule
